// File: rtl/lsu_pkg.sv
// lsu_rmw shared definitions: funct3 codes, FSM states, access checks.
// Optional misalignment trap is selected in lsu_rmw by LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RESP,
        S_RMW,
        S_WR,
        S_ERR
    } state_t;

    function automatic logic f3_legal(
        input logic       we,
        input logic [2:0] f3
    );
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we)
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

    function automatic logic misaligned(
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        logic m;
        m = 1'b0;
        if ((f3 == F3_H) || (f3 == F3_HU))
            m = lo[0];
        else if (f3 == F3_W)
            m = (lo != 2'b00);
        return m;
    endfunction

    function automatic logic [1:0] force_align(
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        logic [1:0] a;
        a = lo;
        if ((f3 == F3_H) || (f3 == F3_HU))
            a = {lo[1], 1'b0};
        else if (f3 == F3_W)
            a = 2'b00;
        return a;
    endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// Core-side request/response channel of the load/store unit.
// master = core, slave = lsu_rmw.
interface lsu_rmw_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, and
// byte/halfword merge into the read word for sub-word stores.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rbuf,
    input  logic [XLEN-1:0] wdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      lo,
    output logic [XLEN-1:0] load_ext,
    output logic [XLEN-1:0] store_merge
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rbuf[{lo, 3'b000} +: 8];
        h = rbuf[{lo[1], 4'b0000} +: 16];
        load_ext = '0;
        unique case (1'b1)
            (funct3 == F3_B):  load_ext = {{(XLEN-8){b[7]}}, b};
            (funct3 == F3_H):  load_ext = {{(XLEN-16){h[15]}}, h};
            (funct3 == F3_W):  load_ext = rbuf;
            (funct3 == F3_BU): load_ext = {{(XLEN-8){1'b0}}, b};
            (funct3 == F3_HU): load_ext = {{(XLEN-16){1'b0}}, h};
            default:           load_ext = '0;
        endcase
    end

    always_comb begin
        store_merge = rbuf;
        unique case (1'b1)
            (funct3 == F3_B): store_merge[{lo, 3'b000} +: 8] = wdata[7:0];
            (funct3 == F3_H): store_merge[{lo[1], 4'b0000} +: 16] = wdata[15:0];
            (funct3 == F3_W): store_merge = wdata;
            default:          store_merge = rbuf;
        endcase
    end
endmodule

// File: rtl/lsu_rmw.sv
// RV32I load/store unit in front of a word-addressed memory.
// LSU_MISALIGN_TRAP_EN: trap misaligned H/W instead of forcing alignment.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    lsu_rmw_if.slave          core,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wd,
    output logic              mem_we,
    input  logic [XLEN-1:0]   mem_rd
);
    state_t            state;
    logic [2:0]        f3_q;
    logic [MEM_AW-1:0] idx_q;
    logic [1:0]        lo_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rbuf;
    logic              rv_q;
    logic              err_q;
    logic              mwe_q;

    logic              bad;
    logic [1:0]        lo_acc;
    logic [XLEN-1:0]   load_ext;
    logic [XLEN-1:0]   store_merge;
    logic              unused_addr;

    assign unused_addr = ^core.req_addr[XLEN-1:MEM_AW+2];

    always_comb begin
        bad    = !f3_legal(core.req_we, core.req_funct3);
        lo_acc = core.req_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        bad = bad | misaligned(core.req_funct3, core.req_addr[1:0]);
`else
        lo_acc = force_align(core.req_funct3, core.req_addr[1:0]);
`endif
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .rbuf        (rbuf),
        .wdata       (wdata_q),
        .funct3      (f3_q),
        .lo          (lo_q),
        .load_ext    (load_ext),
        .store_merge (store_merge)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            f3_q    <= F3_B;
            idx_q   <= '0;
            lo_q    <= '0;
            wdata_q <= '0;
            rbuf    <= '0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            mwe_q   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    rv_q  <= 1'b0;
                    err_q <= 1'b0;
                    mwe_q <= 1'b0;
                    if (core.req_valid) begin
                        f3_q    <= core.req_funct3;
                        idx_q   <= core.req_addr[MEM_AW+1:2];
                        lo_q    <= lo_acc;
                        wdata_q <= core.req_wdata;
                        if (bad) begin
                            state <= S_ERR;
                            rv_q  <= 1'b1;
                            err_q <= 1'b1;
                        end else if (!core.req_we) begin
                            state <= S_RD;
                        end else if (core.req_funct3 == F3_W) begin
                            state <= S_WR;
                            rv_q  <= 1'b1;
                            mwe_q <= 1'b1;
                        end else begin
                            state <= S_RMW;
                        end
                    end
                end
                S_RD: begin
                    rbuf  <= mem_rd;
                    rv_q  <= 1'b1;
                    state <= S_RESP;
                end
                S_RESP: begin
                    rv_q  <= 1'b0;
                    state <= S_IDLE;
                end
                S_RMW: begin
                    rbuf  <= mem_rd;
                    rv_q  <= 1'b1;
                    mwe_q <= 1'b1;
                    state <= S_WR;
                end
                S_WR: begin
                    rv_q  <= 1'b0;
                    mwe_q <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    rv_q  <= 1'b0;
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Reset wins over a pending write even mid-access.
    assign mem_we   = mwe_q & ~rst;
    assign mem_wd   = (state == S_WR) ? store_merge : '0;
    assign mem_addr = (state == S_IDLE) ? '0 : idx_q;

    assign core.req_ready  = (state == S_IDLE);
    assign core.resp_valid = rv_q;
    assign core.resp_err   = err_q;
    assign core.resp_rdata = (state == S_RESP) ? load_ext : '0;
endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: directed vector table, reset abort, and random
// traffic checked against a word-array reference model.
module tb_lsu_rmw;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:1023];
    bit   [31:0] ref_mem [0:1023];
    logic        ld_en = 1'b0;
    logic [9:0]  ld_idx = '0;
    logic [31:0] ld_val = '0;

    int pass_cnt = 0;
    int total = 0;

    lsu_rmw_if #(.XLEN(32)) bus ();

    lsu_rmw #(.MEM_AW(10), .XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .core     (bus.slave),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .mem_we   (mem_we),
        .mem_rd   (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wd;
        else if (ld_en)
            mem[ld_idx] <= ld_val;
    end

    typedef struct {
        string      name;
        bit         we;
        bit [2:0]   f3;
        bit [31:0]  addr;
        bit [31:0]  wdata;
        int         lat;
        bit [31:0]  rdata;
        bit         err;
        bit         wr;
        bit [31:0]  wd;
        bit [31:0]  maddr;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", name, got, exp);
        else
            pass_cnt++;
    endtask

    task automatic poke(input int idx, input bit [31:0] val);
        ld_en  = 1'b1;
        ld_idx = 10'(idx);
        ld_val = val;
        ref_mem[idx] = val;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    // Reference: derived from the access rules with plain arithmetic.
    task automatic model(input bit we, input bit [2:0] f3,
                         input bit [31:0] addr, input bit [31:0] wdata,
                         output int lat, output bit [31:0] rdata,
                         output bit err, output bit wr,
                         output bit [31:0] wd, output bit [31:0] maddr);
        int idx;
        int lo;
        bit legal;
        bit mis;
        bit trap;
        bit [31:0] word, v, mask, nw;
        idx = int'((addr >> 2) & 32'd1023);
        lo = int'(addr % 4);
        legal = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
        mis = (f3 == 1 || f3 == 5) ? (lo % 2 != 0) :
              (f3 == 2) ? (lo != 0) : 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = 1'b1;
`else
        trap = 1'b0;
`endif
        maddr = 32'(idx);
        rdata = 0; err = 0; wr = 0; wd = 0;
        if (!legal || (trap && mis)) begin
            err = 1; lat = 1;
            return;
        end
        if (f3 == 1 || f3 == 5) lo = lo - lo % 2;
        if (f3 == 2) lo = 0;
        word = ref_mem[idx];
        if (!we) begin
            lat = 2;
            case (f3)
                0: begin v = (word >> (8*lo)) % 256;
                         rdata = (v >= 128) ? v - 256 : v; end
                1: begin v = (word >> (8*lo)) % 65536;
                         rdata = (v >= 32768) ? v - 65536 : v; end
                4: rdata = (word >> (8*lo)) % 256;
                5: rdata = (word >> (8*lo)) % 65536;
                default: rdata = word;
            endcase
        end else begin
            lat = (f3 == 2) ? 1 : 2;
            wr = 1;
            if (f3 == 0) begin
                mask = 32'd255 << (8*lo);
                nw = (word & ~mask) | ((wdata % 256) << (8*lo));
            end else if (f3 == 1) begin
                mask = 32'd65535 << (8*lo);
                nw = (word & ~mask) | ((wdata % 65536) << (8*lo));
            end else begin
                nw = wdata;
            end
            ref_mem[idx] = nw;
            wd = nw;
        end
    endtask

    task automatic do_op(input bit we, input bit [2:0] f3,
                         input bit [31:0] addr, input bit [31:0] wdata,
                         output int lat, output logic [31:0] rdata,
                         output logic err, output bit wr,
                         output logic [31:0] wd, output logic [31:0] maddr);
        lat = 0; rdata = 'x; err = 'x; wr = 0; wd = 'x; maddr = 'x;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_we) begin
                wr = 1;
                wd = mem_wd;
            end
            if (bus.resp_valid) begin
                lat = k;
                rdata = bus.resp_rdata;
                err = bus.resp_err;
                maddr = 32'(mem_addr);
                break;
            end
        end
    endtask

    initial begin
        int lat, mlat;
        logic [31:0] rd, wd, ma;
        logic er;
        bit wr, mwr, merr, seen;
        bit [31:0] mrd, mwd, mma;
        int nbad;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        for (int i = 0; i < 1024; i++)
            poke(i, $urandom);
        poke(0, 32'h0102_0304);
        poke(4, 32'hCAFE_F00D);
        poke(5, 32'h8899_AABB);
        poke(8, 32'hFFFF_FFFF);
        poke(9, 32'h1111_2222);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 1);
        chk("rst_rvalid", 32'(bus.resp_valid), 0);
        chk("rst_err", 32'(bus.resp_err), 0);
        chk("rst_rdata", bus.resp_rdata, 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_wd", mem_wd, 0);
        chk("rst_maddr", 32'(mem_addr), 0);

        vt.push_back('{"lb", 0, 0, 32'h16, 0, 2, 32'hFFFF_FF99, 0, 0, 0, 5});
        vt.push_back('{"lbu", 0, 4, 32'h16, 0, 2, 32'h99, 0, 0, 0, 5});
        vt.push_back('{"sb", 1, 0, 32'h15, 32'hCC, 2, 0, 0, 1, 32'h8899_CCBB, 5});
        vt.push_back('{"lw", 0, 2, 32'h14, 0, 2, 32'h8899_CCBB, 0, 0, 0, 5});
        vt.push_back('{"lh", 0, 1, 32'h14, 0, 2, 32'hFFFF_CCBB, 0, 0, 0, 5});
        vt.push_back('{"lhu", 0, 5, 32'h16, 0, 2, 32'h8899, 0, 0, 0, 5});
        vt.push_back('{"sh", 1, 1, 32'h22, 32'h1234, 2, 0, 0, 1, 32'h1234_FFFF, 8});
        vt.push_back('{"sw", 1, 2, 32'h20, 32'hDEAD_BEEF, 1, 0, 0, 1, 32'hDEAD_BEEF, 8});
        vt.push_back('{"lw8", 0, 2, 32'h20, 0, 2, 32'hDEAD_BEEF, 0, 0, 0, 8});
        vt.push_back('{"ill_ld", 0, 3, 32'h14, 0, 1, 0, 1, 0, 0, 5});
        vt.push_back('{"ill_st", 1, 3, 32'h14, 32'h55, 1, 0, 1, 0, 0, 5});
        vt.push_back('{"wrap0", 0, 2, 32'h1000, 0, 2, 32'h0102_0304, 0, 0, 0, 0});
        vt.push_back('{"wrap5", 0, 2, 32'h1014, 0, 2, 32'h8899_CCBB, 0, 0, 0, 5});
`ifdef LSU_MISALIGN_TRAP_EN
        vt.push_back('{"lw_mis", 0, 2, 32'h13, 0, 1, 0, 1, 0, 0, 4});
        vt.push_back('{"sh_mis", 1, 1, 32'h21, 32'h5566, 1, 0, 1, 0, 0, 8});
`else
        vt.push_back('{"lw_mis", 0, 2, 32'h13, 0, 2, 32'hCAFE_F00D, 0, 0, 0, 4});
        vt.push_back('{"sh_mis", 1, 1, 32'h21, 32'h5566, 2, 0, 0, 1, 32'hDEAD_5566, 8});
`endif

        foreach (vt[i]) begin
            do_op(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata,
                  lat, rd, er, wr, wd, ma);
            model(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata,
                  mlat, mrd, merr, mwr, mwd, mma);
            chk({vt[i].name, "_lat"}, 32'(lat), 32'(vt[i].lat));
            chk({vt[i].name, "_rdata"}, rd, vt[i].rdata);
            chk({vt[i].name, "_err"}, 32'(er), 32'(vt[i].err));
            chk({vt[i].name, "_we"}, 32'(wr), 32'(vt[i].wr));
            chk({vt[i].name, "_maddr"}, ma, vt[i].maddr);
            if (vt[i].wr)
                chk({vt[i].name, "_wd"}, wd, vt[i].wd);
        end

        // Reset during the RMW read cycle of an SB must abort it cleanly.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h25;
        bus.req_wdata  = 32'h77;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        rst = 1'b1;
        seen = 0;
        @(negedge clk);
        if (mem_we || bus.resp_valid) seen = 1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        if (mem_we || bus.resp_valid) seen = 1;
        chk("abort_ready", 32'(bus.req_ready), 1);
        chk("abort_quiet", 32'(seen), 0);
        do_op(0, 2, 32'h24, 0, lat, rd, er, wr, wd, ma);
        chk("abort_word9", rd, 32'h1111_2222);

        for (int n = 0; n < 400; n++) begin
            bit we;
            bit [2:0] f3;
            bit [31:0] addr, wdata;
            we = $urandom_range(0, 1) != 0;
            f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 5));
            addr = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom % 256);
            wdata = $urandom;
            do_op(we, f3, addr, wdata, lat, rd, er, wr, wd, ma);
            model(we, f3, addr, wdata, mlat, mrd, merr, mwr, mwd, mma);
            chk("rnd_lat", 32'(lat), 32'(mlat));
            chk("rnd_rdata", rd, mrd);
            chk("rnd_err", 32'(er), 32'(merr));
            chk("rnd_we", 32'(wr), 32'(mwr));
            chk("rnd_maddr", ma, mma);
            if (mwr)
                chk("rnd_wd", wd, mwd);
        end

        @(negedge clk);
        nbad = 0;
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== ref_mem[i]) nbad++;
        chk("mem_final", 32'(nbad), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit placed directly upstream of the word-addressed data memory.
- Converts RV32I byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests from the core into word-index memory accesses.
- Performs read-modify-write for sub-word stores and sign/zero extension for loads.
- Exposes a valid/ready request channel and a one-cycle response pulse, so the core stalls for the duration of each access.

Parameters:
- MEM_AW, 10, memory word-index width (1024 words).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents an access.
- req_ready  out  1  block can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse, access complete.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal funct3, valid with resp_valid.
- mem_addr  out  MEM_AW  word index = addr[MEM_AW+1:2], upper bits dropped (wrap).
- mem_wd  out  32  write word.
- mem_we  out  1  write enable, 1 = write this cycle.
- mem_rd  in  32  combinational read word for mem_addr.

Behaviour:
- Clocking and reset: single clock, clk. Reset is synchronous and active-high on rst. On the edge where rst = 1, the block enters IDLE.
- Reset values: req_ready = 1 after reset; resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_we = 0, mem_wd = 0, mem_addr = 0.
- mem_we is gated by !rst, so no write occurs in any cycle with rst high, including reset asserted mid-operation. An in-flight access is discarded with no resp_valid.
- Handshake: a request is accepted on an edge where req_valid & req_ready are both high. Request fields are latched at that edge. The core holds its fields stable until acceptance.
- States:
  - IDLE: req_ready = 1. On accept:
    - misaligned (H with addr[0] = 1, W with addr[1:0] != 0) or illegal funct3 → ERR;
    - load → RD;
    - SW → WR;
    - SB/SH → RMW.
  - RD: drive mem_addr; capture mem_rd into rbuf; → RESP.
  - RESP: resp_valid = 1. resp_rdata = lane extracted from rbuf by addr[1:0], sign-extended (B/H) or zero-extended (BU/HU). → IDLE.
  - RMW: drive mem_addr; capture mem_rd into rbuf; → WR.
  - WR: mem_we = 1 and resp_valid = 1. mem_wd is:
    - req_wdata for SW;
    - rbuf with byte lane addr[1:0] replaced by wdata[7:0] for SB;
    - rbuf with halfword addr[1] replaced by wdata[15:0] for SH.
    Then → IDLE.
  - ERR: resp_valid = 1, resp_err = 1, no memory access; → IDLE.
- Latency from the accept edge T to the resp_valid cycle: LW/LB/LH T+2; SW T+1; SB/SH T+2; error T+1.
- Throughput: req_ready is low outside IDLE, so back-to-back requests are separated by at least one IDLE cycle.
- mem_addr is held at the latched word index in all non-IDLE states, and is 0 in IDLE.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses go to ERR as above.
- Undefined: there is no misalignment trap. Address low bits are forced aligned (H clears addr[0], W clears addr[1:0]) and the access proceeds normally. resp_err is then asserted only for illegal funct3.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state encoding S_IDLE, S_RD, S_RESP, S_RMW, S_WR, S_ERR;
  - misalignment check function.
- Sub-module lsu_align (purely combinational): inputs rbuf, wdata, funct3, addr[1:0]; outputs load_ext and store_merge. The FSM stays in lsu_rmw.

Test Plan:
- Memory word 5 = 0x8899AABB; LB addr 0x16 → resp_rdata 0xFFFFFF99 at T+2; LBU same address → 0x00000099.
- SB addr 0x15 wdata 0x000000CC over word 5 = 0x8899AABB → RMW read, then WR with mem_wd 0x8899CCBB at T+2; a subsequent LW 0x14 returns 0x8899CCBB.
- SH addr 0x22 wdata 0x1234 over word 8 = 0xFFFFFFFF → mem_wd 0x1234FFFF; SW addr 0x20 0xDEADBEEF → mem_we at T+1, mem_wd 0xDEADBEEF.
- LW addr 0x13 with LSU_MISALIGN_TRAP_EN → resp_err = 1 at T+1 and mem_we never asserted. Without the macro → reads word 4.
- funct3 = 011 → resp_err = 1, resp_rdata = 0. Address 0x00001000 with MEM_AW = 10 → mem_addr wraps to 0.
- rst asserted during the RMW cycle of an SB → no mem_we and no resp_valid; req_ready = 1 the cycle after rst deasserts.
